// File: rtl/aes_req_arbiter.sv
// aes_req_arbiter: two-requester front end for a single AES core.
// One job is in flight at a time; ties in IDLE alternate between requesters.
// Optional BUSY watchdog is compiled in with `define AES_ARB_TIMEOUT_EN
// (limit set by TIMEOUT_CYCLES); without it the arbiter waits in BUSY forever.
//
// state | meaning
// IDLE  | no job; grant a requester combinationally, accept on valid&ready
// START | job latched; core_start pulses for this single cycle
// BUSY  | core running; wait for core_done (or watchdog expiry)
// RESP  | result held for the owner until its rsp_ready
module aes_req_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         reset_n,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic         req0_enc_dec,
    input  logic [1:0]   req0_mode,
    input  logic [255:0] req0_key,
    input  logic [127:0] req0_data,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic         req1_enc_dec,
    input  logic [1:0]   req1_mode,
    input  logic [255:0] req1_key,
    input  logic [127:0] req1_data,

    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [127:0] rsp_data,
    output logic         rsp_err,

    output logic         core_start,
    output logic         core_enc_dec,
    output logic [1:0]   core_mode,
    output logic [255:0] core_key,
    output logic [127:0] core_data_in,
    input  logic [127:0] core_data_out,
    input  logic         core_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t         state_q;
    logic           last_grant_q;
    logic           owner_q;
    logic           enc_dec_q;
    logic [1:0]     mode_q;
    logic [255:0]   key_q;
    logic [127:0]   data_q;
    logic [127:0]   rsp_data_q;
    logic           core_start_q;
    logic           rsp0_valid_q;
    logic           rsp1_valid_q;

    logic           grant0;
    logic           grant1;
    logic           rsp_handshake;
    logic           timeout;

`ifdef AES_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] busy_cnt_q;
    logic             rsp_err_q;

    // The cycle in which the counter would reach the limit is the last BUSY cycle.
    assign timeout = (busy_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign rsp_err = rsp_err_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout = 1'b0;
    assign rsp_err = 1'b0;
`endif

    // Grant in IDLE only; a tie goes to the requester that was not granted last.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (reset_n && state_q == S_IDLE) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant_q;
                grant1 = !last_grant_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready    = grant0;
    assign req1_ready    = grant1;
    assign rsp_handshake = (rsp0_valid_q && rsp0_ready) || (rsp1_valid_q && rsp1_ready);

    // Core inputs come straight from the job registers, so they stay stable for the whole job.
    assign core_start   = core_start_q;
    assign core_enc_dec = enc_dec_q;
    assign core_mode    = mode_q;
    assign core_key     = key_q;
    assign core_data_in = data_q;
    assign rsp_data     = rsp_data_q;
    assign rsp0_valid   = rsp0_valid_q;
    assign rsp1_valid   = rsp1_valid_q;

    // Sequencer: accept, start pulse, wait for the core, hold the result for the owner.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            enc_dec_q    <= 1'b0;
            mode_q       <= 2'b00;
            key_q        <= '0;
            data_q       <= '0;
            rsp_data_q   <= '0;
            core_start_q <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
            busy_cnt_q   <= '0;
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            core_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant0 || grant1) begin
                        owner_q      <= grant1;
                        last_grant_q <= grant1;
                        enc_dec_q    <= grant1 ? req1_enc_dec : req0_enc_dec;
                        mode_q       <= grant1 ? req1_mode    : req0_mode;
                        key_q        <= grant1 ? req1_key     : req0_key;
                        data_q       <= grant1 ? req1_data    : req0_data;
                        core_start_q <= 1'b1;
                        state_q      <= S_START;
                    end
                end
                S_START: begin
`ifdef AES_ARB_TIMEOUT_EN
                    busy_cnt_q <= '0;
`endif
                    state_q <= S_BUSY;
                end
                S_BUSY: begin
                    if (core_done) begin
                        rsp_data_q   <= core_data_out;
`ifdef AES_ARB_TIMEOUT_EN
                        rsp_err_q    <= 1'b0;
`endif
                        rsp0_valid_q <= !owner_q;
                        rsp1_valid_q <= owner_q;
                        state_q      <= S_RESP;
                    end else if (timeout) begin
                        rsp_data_q   <= '0;
`ifdef AES_ARB_TIMEOUT_EN
                        rsp_err_q    <= 1'b1;
`endif
                        rsp0_valid_q <= !owner_q;
                        rsp1_valid_q <= owner_q;
                        state_q      <= S_RESP;
                    end else begin
`ifdef AES_ARB_TIMEOUT_EN
                        busy_cnt_q <= busy_cnt_q + 1'b1;
`endif
                    end
                end
                S_RESP: begin
                    if (rsp_handshake) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Self-checking bench for aes_req_arbiter with a behavioural core stand-in.
module tb_aes_req_arbiter;

    localparam int TO = 64;
    localparam logic [255:0] FIPS_KEY = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic reset_n;
    logic req0_valid, req0_ready, req0_enc_dec;
    logic [1:0] req0_mode;
    logic [255:0] req0_key;
    logic [127:0] req0_data;
    logic req1_valid, req1_ready, req1_enc_dec;
    logic [1:0] req1_mode;
    logic [255:0] req1_key;
    logic [127:0] req1_data;
    logic rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [127:0] rsp_data;
    logic rsp_err;
    logic core_start, core_enc_dec;
    logic [1:0] core_mode;
    logic [255:0] core_key;
    logic [127:0] core_data_in, core_data_out;
    logic core_done;

    aes_req_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_enc_dec(req0_enc_dec),
        .req0_mode(req0_mode), .req0_key(req0_key), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_enc_dec(req1_enc_dec),
        .req1_mode(req1_mode), .req1_key(req1_key), .req1_data(req1_data),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .core_start(core_start), .core_enc_dec(core_enc_dec), .core_mode(core_mode),
        .core_key(core_key), .core_data_in(core_data_in),
        .core_data_out(core_data_out), .core_done(core_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Stand-in for the AES core: the FIPS-197 vector gives its real ciphertext,
    // everything else a cheap mix of all job fields so pass-through errors show.
    function automatic logic [127:0] fake_core(input logic e, input logic [1:0] m,
                                               input logic [255:0] k, input logic [127:0] d);
        if (!e && m == 2'b00 && k == FIPS_KEY && d == FIPS_PT) return FIPS_CT;
        return d ^ k[255:128] ^ {k[126:0], k[127]} ^ {m, e, 125'h0} ^ 128'h3c3c_0ff0;
    endfunction

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        logic         owner;
        logic [127:0] data;
        logic         err;
    } exp_t;

    exp_t q[$];
    exp_t t;
    bit   m_busy = 0, m_started = 0, m_done = 0, m_last = 1;
    int   m_bcnt = 0;
    logic m_e;
    logic [1:0] m_m;
    logic [255:0] m_k;
    logic [127:0] m_d;
    logic e0, e1;

    always @(negedge clk) begin
        if (reset_n) begin
            e0 = 1'b0;
            e1 = 1'b0;
            if (!m_busy) begin
                if (req0_valid && req1_valid) begin
                    e0 = m_last;
                    e1 = !m_last;
                end else begin
                    e0 = req0_valid;
                    e1 = req1_valid;
                end
            end
            check("req0_ready", req0_ready, e0);
            check("req1_ready", req1_ready, e1);

            if (rsp0_valid || rsp1_valid) begin
                check("rsp_one_hot", rsp0_valid && rsp1_valid, 0);
                if (q.size() == 0 || !m_done) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    check("rsp_owner", rsp1_valid, q[0].owner);
                    check("rsp_data", rsp_data, q[0].data);
                    check("rsp_err", rsp_err, q[0].err);
                    if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                        void'(q.pop_front());
                        m_busy = 0;
                        m_started = 0;
                        m_done = 0;
                    end
                end
            end else if (m_done) begin
                check("rsp_latency", 0, 1);
            end

            if (!m_busy) begin
                check("core_start_idle", core_start, 0);
                if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                    t.owner = req1_ready;
                    m_e = t.owner ? req1_enc_dec : req0_enc_dec;
                    m_m = t.owner ? req1_mode : req0_mode;
                    m_k = t.owner ? req1_key : req0_key;
                    m_d = t.owner ? req1_data : req0_data;
                    t.data = fake_core(m_e, m_m, m_k, m_d);
                    t.err = 1'b0;
                    q.push_back(t);
                    m_busy = 1;
                    m_started = 0;
                    m_done = 0;
                    m_last = t.owner;
                end
            end else if (!m_done) begin
                if (core_start) begin
                    check("core_start_once", m_started, 0);
                    check("core_enc_dec", core_enc_dec, m_e);
                    check("core_mode", core_mode, m_m);
                    check("core_key", core_key, m_k);
                    check("core_data_in", core_data_in, m_d);
                    m_started = 1;
                    m_bcnt = 0;
                end else if (m_started) begin
                    if (core_done) begin
                        m_done = 1;
                    end
`ifdef AES_ARB_TIMEOUT_EN
                    else begin
                        m_bcnt++;
                        if (m_bcnt == TO) begin
                            t = q[0];
                            t.data = '0;
                            t.err = 1'b1;
                            q[0] = t;
                            m_done = 1;
                        end
                    end
`endif
                end else begin
                    check("core_start_missing", 0, 1);
                end
            end else begin
                check("core_start_resp", core_start, 0);
            end
        end
    end

    // ---------------- core stand-in ----------------
    int   fixed_lat = 0;
    int   pend = 0;
    bit   withhold = 0, junk_in_start = 0, inject_done = 0;
    logic [127:0] pend_data;

    initial begin
        core_done = 1'b0;
        core_data_out = '0;
        pend_data = '0;
        forever begin
            @(posedge clk);
            #1;
            core_done = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    core_done = 1'b1;
                    core_data_out = pend_data;
                end
            end
            if (core_start) begin
                pend_data = fake_core(core_enc_dec, core_mode, core_key, core_data_in);
                pend = withhold ? 0 : (fixed_lat > 0 ? fixed_lat : $urandom_range(1, 6));
                if (junk_in_start) begin
                    core_done = 1'b1;
                    core_data_out = {$urandom, $urandom, $urandom, $urandom};
                end
            end
            if (inject_done) begin
                core_done = 1'b1;
                core_data_out = {$urandom, $urandom, $urandom, $urandom};
                inject_done = 0;
            end
        end
    end

    // ---------------- response-side ready ----------------
    bit rsp_rand = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rsp_rand) begin
                rsp0_ready = 1'($urandom_range(0, 1));
                rsp1_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input int who, input logic e, input logic [1:0] m,
                         input logic [255:0] k, input logic [127:0] d);
        bit got = 0;
        int n = 0;
        if (who == 0) begin
            req0_enc_dec = e; req0_mode = m; req0_key = k; req0_data = d; req0_valid = 1'b1;
        end else begin
            req1_enc_dec = e; req1_mode = m; req1_key = k; req1_data = d; req1_valid = 1'b1;
        end
        while (!got && n < 400) begin
            @(negedge clk);
            got = (who == 0) ? req0_ready : req1_ready;
            n++;
        end
        @(posedge clk);
        #1;
        if (who == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
        if (!got) check("accept_timeout", 0, 1);
    endtask

    task automatic rand_job(input int who);
        issue(who, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom});
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((m_busy || q.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (m_busy || q.size() != 0) check("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_rsp0_valid", rsp0_valid, 0);
        check("rst_rsp1_valid", rsp1_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_core_start", core_start, 0);
        check("rst_core_enc_dec", core_enc_dec, 0);
        check("rst_core_mode", core_mode, 0);
        check("rst_core_key", core_key, 0);
        check("rst_core_data_in", core_data_in, 0);
        q.delete();
        m_busy = 0;
        m_started = 0;
        m_done = 0;
        m_last = 1;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        reset_n = 1'b1;
        req0_valid = 0; req0_enc_dec = 0; req0_mode = 0; req0_key = '0; req0_data = '0;
        req1_valid = 0; req1_enc_dec = 0; req1_mode = 0; req1_key = '0; req1_data = '0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        #2;
        do_reset();

        // FIPS-197 AES-128 encipher on requester 0
        issue(0, 1'b0, 2'b00, FIPS_KEY, FIPS_PT);
        wait_idle();

        // Simultaneous requests after reset, then a re-request from 0 while 1 waits
        do_reset();
        fork
            begin
                rand_job(0);
                rand_job(0);
            end
            rand_job(1);
        join
        wait_idle();
        fork
            rand_job(0);
            rand_job(1);
        join
        wait_idle();

        // Owner stalls its response for 10 cycles while the other requester waits
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b1;
        fork
            rand_job(0);
            begin
                repeat (3) @(posedge clk);
                #1;
                rand_job(1);
            end
            begin
                w = 0;
                while (!rsp0_valid && w < 200) begin
                    @(negedge clk);
                    w++;
                end
                check("stall_rsp0_seen", rsp0_valid, 1);
                repeat (10) @(negedge clk);
                @(posedge clk);
                #1;
                rsp0_ready = 1'b1;
            end
        join
        wait_idle();

        // Stray core_done in IDLE and in START
        inject_done = 1;
        repeat (3) @(negedge clk);
        check("idle_done_rsp0", rsp0_valid, 0);
        check("idle_done_rsp1", rsp1_valid, 0);
        @(posedge clk);
        #1;
        junk_in_start = 1;
        rand_job(1);
        wait_idle();
        junk_in_start = 0;

        // Reset during BUSY; the late core_done must be ignored
        fixed_lat = 10;
        rand_job(1);
        repeat (4) @(posedge clk);
        #1;
        do_reset();
        fixed_lat = 0;
        repeat (15) @(negedge clk);
        check("late_done_rsp0", rsp0_valid, 0);
        check("late_done_rsp1", rsp1_valid, 0);
        @(posedge clk);
        #1;
        rand_job(1);
        wait_idle();

`ifdef AES_ARB_TIMEOUT_EN
        withhold = 1;
        rand_job(0);
        wait_idle();
        withhold = 0;
        fixed_lat = TO;
        rand_job(1);
        wait_idle();
        fixed_lat = 0;
`else
        withhold = 1;
        rand_job(0);
        repeat (100) @(posedge clk);
        #1;
        check("withheld_no_rsp", rsp0_valid | rsp1_valid, 0);
        do_reset();
        withhold = 0;
`endif

        // Random traffic from both requesters with random response back-pressure
        rsp_rand = 1;
        fork
            for (int i = 0; i < 15; i++) begin
                repeat ($urandom_range(0, 4)) @(posedge clk);
                #1;
                rand_job(0);
            end
            for (int j = 0; j < 15; j++) begin
                repeat ($urandom_range(0, 4)) @(posedge clk);
                #1;
                rand_job(1);
            end
        join
        wait_idle();
        rsp_rand = 0;

        check("scoreboard_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
